// File: rtl/mul_seq.sv
// Sequencer for a shift-add 16x16 unsigned multiply and a double-length left shift.
// It drives the control strobes of an external AC/SH/A datapath and reads back its status bits.
module mul_seq (
   input  logic       clk,
   input  logic       MCL,
   input  logic       START,
   input  logic       OP,
   input  logic [3:0] N,
   input  logic       SH0,
   input  logic       SH15,
   input  logic       AC0,
   input  logic       CO,
   output logic       BUSY,
   output logic       DONE,
   output logic       AKL,
   output logic       ACKL,
   output logic       SHKL,
   output logic       M,
   output logic       C,
   output logic       SHM,
   output logic       SHX,
   output logic       BC0,
   output logic       BC15,
   output logic [1:0] SHS,
   output logic [2:0] SL,
   output logic [3:0] S
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LDSH  = 3'd1,
      ST_CLRAC = 3'd2,
      ST_ADD   = 3'd3,
      ST_SHF   = 3'd4,
      ST_SHL   = 3'd5,
      ST_FIN   = 3'd6
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_next;
   logic       r_cy;
   logic       w_cy_next;

   // State, iteration counter and carry flop; master clear acts immediately.
   always_ff @(posedge clk or posedge MCL) begin
      if (MCL) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_cy    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         r_cy    <= w_cy_next;
      end
   end

   // Next-state, counter and carry update.
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_cy_next  = r_cy;
      case (r_state)
         ST_IDLE: begin
            if (START) begin
               w_cnt_next = N;
               if (!OP) begin
                  w_next = ST_LDSH;
               end else if (N != 4'd0) begin
                  w_next = ST_SHL;
               end else begin
                  w_next = ST_FIN;
               end
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_LDSH: begin
            w_next = ST_CLRAC;
         end
         ST_CLRAC: begin
            w_next     = ST_ADD;
            w_cnt_next = 4'd15;
         end
         ST_ADD: begin
            w_next    = ST_SHF;
            w_cy_next = CO;
         end
         ST_SHF: begin
            if (r_cnt == 4'd0) begin
               w_next = ST_FIN;
            end else begin
               w_next     = ST_ADD;
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         ST_SHL: begin
            // A zero count here is unreachable; treat it like the last step.
            w_cnt_next = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
               w_next = ST_FIN;
            end else begin
               w_next = ST_SHL;
            end
         end
         ST_FIN: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next     = ST_IDLE;
            w_cnt_next = 4'd0;
            w_cy_next  = 1'b0;
         end
      endcase
   end

   // Datapath control decode from the current state.
   always_comb begin
      BUSY = 1'b0;
      DONE = 1'b0;
      AKL  = 1'b0;
      ACKL = 1'b0;
      SHKL = 1'b0;
      M    = 1'b0;
      C    = 1'b0;
      SHM  = 1'b0;
      SHX  = 1'b0;
      BC0  = 1'b0;
      BC15 = 1'b0;
      SHS  = 2'd0;
      SL   = 3'd0;
      S    = 4'd0;
      case (r_state)
         ST_IDLE: begin
            BUSY = 1'b0;
         end
         ST_LDSH: begin
            BUSY = 1'b1;
            AKL  = 1'b1;
            SL   = 3'd7;
            M    = 1'b1;
            S    = 4'o17;
            SHKL = 1'b1;
            SHS  = 2'd3;
         end
         ST_CLRAC: begin
            BUSY = 1'b1;
            M    = 1'b1;
            S    = 4'o14;
            ACKL = 1'b1;
         end
         ST_ADD: begin
            BUSY = 1'b1;
            SL   = 3'd3;
            ACKL = 1'b1;
            if (SH0) begin
               S = 4'o01;
            end else begin
               S = 4'o03;
            end
         end
         ST_SHF: begin
            // Carry enters AC from the top while AC[0] moves into SH.
            BUSY = 1'b1;
            SL   = 3'd4;
            BC0  = r_cy;
            M    = 1'b1;
            S    = 4'o17;
            ACKL = 1'b1;
            SHKL = 1'b1;
            SHS  = 2'd2;
            SHM  = AC0;
         end
         ST_SHL: begin
            BUSY = 1'b1;
            SL   = 3'd5;
            BC15 = SH15;
            M    = 1'b1;
            S    = 4'o17;
            ACKL = 1'b1;
            SHKL = 1'b1;
            SHS  = 2'd1;
            SHX  = 1'b0;
         end
         ST_FIN: begin
            BUSY = 1'b1;
            DONE = 1'b1;
         end
         default: begin
            BUSY = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: emulates the external AC/SH/A datapath and checks every cycle
// against a schedule model (cycle index within the operation) plus arithmetic results.
module tb_mul_seq;

   logic       clk = 1'b0;
   logic       MCL, START, OP;
   logic [3:0] N;
   logic       SH0, SH15, AC0, CO;
   logic       BUSY, DONE, AKL, ACKL, SHKL, M, C, SHM, SHX, BC0, BC15;
   logic [1:0] SHS;
   logic [2:0] SL;
   logic [3:0] S;

   always #5 clk = ~clk;

   mul_seq dut (
      .clk(clk), .MCL(MCL), .START(START), .OP(OP), .N(N),
      .SH0(SH0), .SH15(SH15), .AC0(AC0), .CO(CO),
      .BUSY(BUSY), .DONE(DONE), .AKL(AKL), .ACKL(ACKL), .SHKL(SHKL),
      .M(M), .C(C), .SHM(SHM), .SHX(SHX), .BC0(BC0), .BC15(BC15),
      .SHS(SHS), .SL(SL), .S(S)
   );

   // datapath emulation
   logic [15:0] r_ac, r_sh, r_a, r_aa, r_bb;
   logic        pre_req;
   logic [31:0] pre_val;
   logic [16:0] w_alu;
   logic [15:0] w_bus;

   assign SH0  = r_sh[0];
   assign SH15 = r_sh[15];
   assign AC0  = r_ac[0];

   always_comb begin
      w_alu = {1'b0, r_ac} + ((M == 1'b0 && S == 4'o01) ? {1'b0, r_a} : 17'd0);
      CO    = (M == 1'b0) ? w_alu[16] : 1'b0;
      if (M) w_bus = (S == 4'o17) ? r_bb : 16'd0;
      else   w_bus = w_alu[15:0];
   end

   always @(posedge clk) begin
      if (pre_req) begin
         r_ac <= pre_val[31:16];
         r_sh <= pre_val[15:0];
      end else begin
         if (AKL) r_a <= r_aa;
         if (ACKL) begin
            case (SL)
               3'd4:    r_ac <= {BC0, r_ac[15:1]};
               3'd5:    r_ac <= {r_ac[14:0], BC15};
               default: r_ac <= w_bus;
            endcase
         end
         if (SHKL) begin
            case (SHS)
               2'd3:    r_sh <= w_bus;
               2'd2:    r_sh <= {SHM, r_sh[15:1]};
               2'd1:    r_sh <= {r_sh[14:0], SHX};
               default: r_sh <= r_sh;
            endcase
         end
      end
   end

   // behavioural model: operation in flight, cycle index, expected result
   bit          m_act, m_op, m_cy;
   int          m_k, m_len;
   logic [31:0] m_res;
   logic [16:0] m_sum;

   always @(posedge clk or posedge MCL) begin
      if (MCL) begin
         m_act <= 1'b0;
         m_k   <= 0;
         m_cy  <= 1'b0;
      end else if (!m_act) begin
         if (START) begin
            m_act <= 1'b1;
            m_k   <= 1;
            m_op  <= OP;
            m_len <= OP ? int'(N) + 1 : 35;
            m_res <= OP ? ({r_ac, r_sh} << N) : ({16'd0, r_aa} * {16'd0, r_bb});
         end
      end else begin
         if (!m_op && m_k >= 3 && m_k <= 33 && (m_k % 2) == 1) begin
            m_sum = {1'b0, r_ac} + (r_sh[0] ? {1'b0, r_a} : 17'd0);
            m_cy <= m_sum[16];
         end
         if (m_k == m_len) m_act <= 1'b0;
         else              m_k   <= m_k + 1;
      end
   end

   function automatic logic [19:0] f_exp(input bit act, input bit op, input int k, input int len,
                                          input logic sh0, input logic sh15, input logic ac0, input bit cy);
      logic busy, done, akl, ackl, shkl, m, c, shm, shx, bc0, bc15;
      logic [1:0] shs;
      logic [2:0] sl;
      logic [3:0] s;
      {busy, done, akl, ackl, shkl, m, c, shm, shx, bc0, bc15} = 11'd0;
      shs = 2'd0; sl = 3'd0; s = 4'd0;
      if (act) begin
         busy = 1'b1;
         if (k == len) done = 1'b1;
         else if (op) begin
            sl = 3'd5; bc15 = sh15; m = 1'b1; s = 4'o17; ackl = 1'b1; shkl = 1'b1; shs = 2'd1;
         end else if (k == 1) begin
            akl = 1'b1; sl = 3'd7; m = 1'b1; s = 4'o17; shkl = 1'b1; shs = 2'd3;
         end else if (k == 2) begin
            m = 1'b1; s = 4'o14; ackl = 1'b1;
         end else if ((k % 2) == 1) begin
            sl = 3'd3; ackl = 1'b1; s = sh0 ? 4'o01 : 4'o03;
         end else begin
            sl = 3'd4; bc0 = cy; m = 1'b1; s = 4'o17; ackl = 1'b1; shkl = 1'b1; shs = 2'd2; shm = ac0;
         end
      end
      return {busy, done, akl, ackl, shkl, m, c, shm, shx, bc0, bc15, shs, sl, s};
   endfunction

   // compare process
   int          total = 0, bad = 0;
   int          done_cnt = 0;
   logic        lit_en, t_out;
   bit          t_seen = 1'b0;
   logic [31:0] lit_res;
   int          lit_cyc;
   logic [19:0] w_got, w_exp;

   assign w_got = {BUSY, DONE, AKL, ACKL, SHKL, M, C, SHM, SHX, BC0, BC15, SHS, SL, S};

   always @(negedge clk) begin
      if (START && !m_act && !MCL) done_cnt = 0;
      else                         done_cnt = done_cnt + 1;
      w_exp = f_exp(m_act, m_op, m_k, m_len, SH0, SH15, AC0, m_cy);
      total = total + 1;
      if (w_got !== w_exp) begin
         bad = bad + 1;
         $display("FAIL ctl t=%0t got=%h exp=%h", $time, w_got, w_exp);
      end
      total = total + 1;
      if (M === 1'b1 && S < 4'd4) begin
         bad = bad + 1;
         $display("FAIL mode_code t=%0t got S=%0d with M=1 exp S>=4", $time, S);
      end
      if (m_act && m_k == m_len) begin
         total = total + 1;
         if ({r_ac, r_sh} !== m_res) begin
            bad = bad + 1;
            $display("FAIL result t=%0t got=%h exp=%h", $time, {r_ac, r_sh}, m_res);
         end
      end
      if (DONE === 1'b1 && lit_en) begin
         total = total + 3;
         if (done_cnt != lit_cyc) begin
            bad = bad + 1;
            $display("FAIL latency got=%0d exp=%0d", done_cnt, lit_cyc);
         end
         if ({r_ac, r_sh} !== lit_res) begin
            bad = bad + 1;
            $display("FAIL lit_result got=%h exp=%h", {r_ac, r_sh}, lit_res);
         end
         if (m_res !== lit_res) begin
            bad = bad + 1;
            $display("FAIL model_pin got=%h exp=%h", m_res, lit_res);
         end
      end
      if (t_out && !t_seen) begin
         t_seen = 1'b1;
         total  = total + 1;
         bad    = bad + 1;
         $display("FAIL done_timeout got=no DONE exp=DONE within 200 cycles");
      end
   end

   // stimulus
   task automatic run_op(input logic op, input logic [3:0] n, input logic [15:0] aa,
                         input logic [15:0] bb, input logic [31:0] pre, input logic len,
                         input logic [31:0] lres, input int lcyc, input logic poke, input int abort_at);
      int cyc;
      @(posedge clk); #1;
      lit_en = len; lit_res = lres; lit_cyc = lcyc;
      if (op) begin
         pre_req = 1'b1; pre_val = pre;
         @(posedge clk); #1;
         pre_req = 1'b0;
      end
      START = 1'b1; OP = op; N = n; r_aa = aa; r_bb = bb;
      @(posedge clk); #1;
      START = 1'b0;
      cyc = 1;
      while (DONE !== 1'b1 && cyc < 200) begin
         if (cyc >= 2) begin
            r_aa = 16'($urandom); r_bb = 16'($urandom);
         end
         if (poke && (cyc == 5 || cyc == 20)) begin
            START = 1'b1; OP = 1'($urandom); N = 4'($urandom);
         end else begin
            START = 1'b0;
         end
         if (cyc == abort_at) begin
            MCL = 1'b1;
            repeat (3) @(posedge clk);
            #1 MCL = 1'b0;
            START = 1'b0;
            return;
         end
         @(posedge clk); #1;
         cyc = cyc + 1;
      end
      START = 1'b0;
      if (cyc >= 200) t_out = 1'b1;
   endtask

   initial begin
      MCL = 1'b1; START = 1'b0; OP = 1'b0; N = 4'd0;
      r_aa = 16'd0; r_bb = 16'd0; pre_req = 1'b0; pre_val = 32'd0;
      lit_en = 1'b0; lit_res = 32'd0; lit_cyc = 0; t_out = 1'b0;
      repeat (3) @(posedge clk);
      #1 MCL = 1'b0;
      run_op(1'b0, 4'd0, 16'd3, 16'd5, 32'd0, 1'b1, 32'h0000_000F, 35, 1'b0, -1);
      run_op(1'b0, 4'd0, 16'hFFFF, 16'hFFFF, 32'd0, 1'b1, 32'hFFFE_0001, 35, 1'b0, -1);
      run_op(1'b1, 4'd4, 16'd0, 16'd0, 32'h1234_8000, 1'b1, 32'h2348_0000, 5, 1'b0, -1);
      run_op(1'b1, 4'd0, 16'd0, 16'd0, 32'hCAFE_5A5A, 1'b1, 32'hCAFE_5A5A, 1, 1'b0, -1);
      run_op(1'b1, 4'd15, 16'd0, 16'd0, 32'h8000_0001, 1'b1, 32'h0000_8000, 16, 1'b0, -1);
      run_op(1'b0, 4'd0, 16'd300, 16'd700, 32'd0, 1'b1, 32'h0003_3450, 35, 1'b1, -1);
      run_op(1'b0, 4'd0, 16'd3, 16'd5, 32'd0, 1'b0, 32'd0, 0, 1'b0, 10);
      run_op(1'b0, 4'd0, 16'd3, 16'd5, 32'd0, 1'b1, 32'h0000_000F, 35, 1'b0, -1);
      for (int i = 0; i < 24; i++) begin
         run_op(1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), $urandom,
                1'b0, 32'd0, 0, 1'($urandom), -1);
      end
      repeat (3) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
